// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_queue                                                 |
// | Purpose  : Instruction prefetch queue between fetch and decode.        |
// |            Captures {PC, Instr} pairs into a circular FIFO, presents   |
// |            the oldest entry to decode via valid/ready, stalls the PC   |
// |            when full, and supports a redirect flush that can retain    |
// |            the branch delay-slot entry.                                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 4,  // number of entries, power of two, >= 2
  parameter int AW    = 2   // pointer width, log2(DEPTH)
) (
  input  logic          CLK,
  input  logic          Reset,
  // fetch side
  input  logic          IF_Valid,
  input  logic [31:0]   IF_PC,
  input  logic [31:0]   IF_Instr,
  output logic          IF_Stall,
  // decode side
  input  logic          ID_Ready,
  output logic          ID_Valid,
  output logic [31:0]   ID_PC,
  output logic [31:0]   ID_Instr,
  output logic [31:0]   ID_PC8,
  // redirect control
  input  logic          Flush,
  input  logic          KeepSlot,
  // occupancy
  output logic [AW:0]   Count
);

  // Occupancy value that means "every entry holds a valid pair".
  localparam logic [AW:0] C_CNT_FULL = (AW+1)'(DEPTH);
  // Link-address offset: jal/jalr return past the delay slot.
  localparam logic [31:0] C_LINK_OFS = 32'd8;

  // ---------------------------------------------------------------------
  // Storage and pointer state
  // ---------------------------------------------------------------------
  logic [31:0] mem_pc_q    [DEPTH];
  logic [31:0] mem_instr_q [DEPTH];

  logic [AW-1:0] rd_q,  rd_d;
  logic [AW-1:0] wr_q,  wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // ---------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------
  logic          full_w;
  logic          empty_w;
  logic          push_w;
  logic          pop_w;
  logic [AW-1:0] pop_inc_w;   // pop zero-extended to pointer width
  logic [AW-1:0] rd_pop_w;    // head pointer after this cycle's pop
  logic [AW:0]   cnt_pop_w;   // occupancy after this cycle's pop
  logic          keep_w;      // flush keeps the delay-slot entry

  // Status flags and push/pop qualification; all flags derive only from
  // registered occupancy, so IF_Stall never depends on this cycle's inputs.
  always_comb begin
    full_w    = (cnt_q == C_CNT_FULL);
    empty_w   = (cnt_q == '0);
    // A flush cycle never pushes: the pair being fetched is on the wrong path.
    push_w    = IF_Valid && !full_w && !Flush;
    // Decode consumes the head only when one is being presented.
    pop_w     = !empty_w && ID_Ready;
    pop_inc_w = {{(AW-1){1'b0}}, pop_w};
    rd_pop_w  = rd_q + pop_inc_w;
    cnt_pop_w = cnt_q - {{AW{1'b0}}, pop_w};
    // Only keep a slot when something actually remains after the pop.
    keep_w    = KeepSlot && (cnt_pop_w != '0);
  end

  // Next-state selection for pointers and occupancy; Flush outranks push/pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (Flush) begin
      // The pop still retires the branch; the queue is then cut back.
      rd_d = rd_pop_w;
      if (keep_w) begin
        // Retain exactly the entry following the branch (its delay slot).
        wr_d  = rd_pop_w + {{(AW-1){1'b0}}, 1'b1};
        cnt_d = {{AW{1'b0}}, 1'b1};
      end else begin
        wr_d  = rd_pop_w;
        cnt_d = '0;
      end
    end else begin
      rd_d  = rd_pop_w;
      wr_d  = wr_q + {{(AW-1){1'b0}}, push_w};
      // Simultaneous push and pop cancel, leaving occupancy unchanged.
      cnt_d = cnt_q + {{AW{1'b0}}, push_w} - {{AW{1'b0}}, pop_w};
    end
  end

  // Pointer and occupancy registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge CLK) begin
    if (push_w && !Reset) begin
      mem_pc_q[wr_q]    <= IF_PC;
      mem_instr_q[wr_q] <= IF_Instr;
    end
  end

  // ---------------------------------------------------------------------
  // Decode-side output mux
  // ---------------------------------------------------------------------

  // Present the head entry, or a zero PC with an all-zero word (sll nop)
  // when empty, so decode never sees stale storage.
  always_comb begin
    ID_Valid = !empty_w;
    ID_PC    = '0;
    ID_Instr = '0;
    if (!empty_w) begin
      ID_PC    = mem_pc_q[rd_q];
      ID_Instr = mem_instr_q[rd_q];
    end
    ID_PC8   = ID_PC + C_LINK_OFS;
    IF_Stall = full_w;
    Count    = cnt_q;
  end

endmodule
`default_nettype wire
